hgc_pixel_fetch: RTL

Character/pixel fetch and serialiser stage directly upstream of the Hercules attribute stage.
- Text mode: samples char/attribute words from VRAM, looks up the font ROM row, and serialises 9-dot glyph rows (with line-graphics column extension).
- Graphics mode: serialises 16-bit pixel words.
- Emits pix_in, att_byte, row_addr, display_enable, cursor and pix_750, all aligned to the same dot, for the attribute stage.

---
 rtl/hgc_pkg.sv | 25 ++
 rtl/hgc_dot_shifter.sv | 26 ++
 rtl/hgc_pixel_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/hgc_pkg.sv
// Shared constants, the stage A cell record and the line-graphics range test
// for the Hercules pixel fetch path.
package hgc_pkg;

  localparam int TEXT_DOTS = 9;
  localparam int GRPH_DOTS = 16;
  localparam int FONT_AW   = 12;

  localparam logic [7:0] LINE_GFX_LO = 8'hC0;
  localparam logic [7:0] LINE_GFX_HI = 8'hDF;

  // One sampled VRAM cell plus the CRTC context that travels with it.
  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] chr;
    logic [4:0] row;
    logic       de;
    logic       cur;
  } cell_t;

  function automatic logic is_line_gfx(input logic [7:0] c);
    return (c >= LINE_GFX_LO) && (c <= LINE_GFX_HI);
  endfunction

endpackage

// File: rtl/hgc_dot_shifter.sv
// Loadable left shifter, 16 bits wide in graphics mode and 9 bits in text mode.
// Text words are left-justified on load, so the MSB is the first dot in both modes.
module hgc_dot_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        mode,
  input  logic [15:0] din,
  output logic        msb
);

  logic [15:0] sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= '0;
    end else if (load) begin
      sh <= mode ? din : {din[8:0], 7'b0};
    end else begin
      sh <= {sh[14:0], 1'b0};
    end
  end

  assign msb = sh[15];

endmodule

// File: rtl/hgc_pixel_fetch.sv
// Character/pixel fetch and serialiser: a cell sampled at dot 0 of one cell is shown
// on dots 0..N-1 of the next, with its attribute, row, enable and cursor held alongside.
module hgc_pixel_fetch
  import hgc_pkg::*;
#(
  parameter int          TEXT_DOTS = hgc_pkg::TEXT_DOTS,
  parameter int          GRPH_DOTS = hgc_pkg::GRPH_DOTS,
  parameter int unsigned LINE_GFX  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               grph_mode,
  input  logic [15:0]        vram_data,
  input  logic [4:0]         row_addr_in,
  input  logic               display_enable_in,
  input  logic               cursor_in,
  output logic               char_strobe,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  output logic               pix_out,
  output logic               pix_750,
  output logic [7:0]         att_byte,
  output logic [4:0]         row_addr_out,
  output logic               display_enable_out,
  output logic               cursor_out
);

  localparam logic [3:0] TEXT_LAST = 4'(TEXT_DOTS - 1);
  localparam logic [3:0] GRPH_LAST = 4'(GRPH_DOTS - 1);

  logic [3:0]  dot_cnt, dot_nxt, last_cur, last_nxt;
  logic        mode_r, mode_nxt, wrap;
  cell_t       cell_a;
  logic [7:0]  font_a;
  logic        mode_b;
  logic        ext;
  logic [15:0] word;
  logic        sh_msb;

  // Mode only changes on the wrap cycle, so the next cell's length is known here
  // and the registered strobe can land exactly on that cell's last dot.
  always_comb begin
    last_cur = mode_r ? GRPH_LAST : TEXT_LAST;
    wrap     = (dot_cnt == last_cur);
    dot_nxt  = wrap ? 4'd0 : dot_cnt + 4'd1;
    mode_nxt = wrap ? grph_mode : mode_r;
    last_nxt = mode_nxt ? GRPH_LAST : TEXT_LAST;
  end

  always_comb begin
    ext  = (LINE_GFX != 0) && is_line_gfx(cell_a.chr) && font_a[0];
    word = mode_r ? {cell_a.attr, cell_a.chr} : {7'b0, font_a, ext};
    if (!cell_a.de) begin
      word = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dot_cnt            <= '0;
      mode_r             <= 1'b0;
      char_strobe        <= 1'b0;
      font_addr          <= '0;
      cell_a             <= '0;
      font_a             <= '0;
      mode_b             <= 1'b0;
      att_byte           <= '0;
      row_addr_out       <= '0;
      display_enable_out <= 1'b0;
      cursor_out         <= 1'b0;
    end else begin
      dot_cnt     <= dot_nxt;
      mode_r      <= mode_nxt;
      char_strobe <= (dot_nxt == last_nxt);
      if (dot_cnt == 4'd0) begin
        cell_a <= '{attr: vram_data[15:8], chr: vram_data[7:0], row: row_addr_in,
                    de: display_enable_in, cur: cursor_in};
      end
      // Only row[3:0] addresses the font; row 16+ wraps but is forwarded whole.
      if (dot_cnt == 4'd1) begin
        font_addr <= {cell_a.chr, cell_a.row[3:0]};
      end
      if (dot_cnt == 4'd3) begin
        font_a <= font_data;
      end
      if (wrap) begin
        mode_b             <= mode_r;
        att_byte           <= cell_a.attr;
        row_addr_out       <= cell_a.row;
        display_enable_out <= cell_a.de;
        cursor_out         <= cell_a.cur;
      end
    end
  end

  hgc_dot_shifter u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (wrap),
    .mode  (mode_r),
    .din   (word),
    .msb   (sh_msb)
  );

  assign pix_out = sh_msb & ~mode_b;
  assign pix_750 = sh_msb & mode_b;

endmodule
